// File: rtl/mont_exp_pkg.sv
// Shared definitions for the Montgomery-domain square-and-multiply sequencer.
// Holds the operand width, the state encoding and the exponent bit counter limits.
package mont_exp_pkg;

  localparam int WIDTH = 381;
  localparam int CNT_W = 9;

  // Value of the consumed-bit counter at the moment exponent bit 0 is being consumed.
  localparam logic [CNT_W-1:0] TERM_COUNT = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SCAN     = 3'd1,
    ST_SQ_ISSUE = 3'd2,
    ST_SQ_WAIT  = 3'd3,
    ST_MU_ISSUE = 3'd4,
    ST_MU_WAIT  = 3'd5,
    ST_ADV      = 3'd6,
    ST_DONE     = 3'd7
  } state_e;

endpackage

// File: rtl/mont_exp.sv
// Left-to-right square-and-multiply exponentiation sequencer driving an external
// Montgomery multiplier; the accumulator starts at the Montgomery one and ends at x^e.
module mont_exp
  import mont_exp_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_e,
  input  logic [WIDTH-1:0] in_one,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             mul_start,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  input  logic             mul_done,
  input  logic [WIDTH-1:0] mul_result
);

  state_e           state_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] e_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mul_a_q;
  logic [WIDTH-1:0] mul_b_q;
  logic [CNT_W-1:0] count_q;

  logic             e_msb;
  logic             last_bit;
  logic [WIDTH-1:0] e_shl;
  logic [CNT_W-1:0] count_inc;

  assign e_msb     = e_q[WIDTH-1];
  assign last_bit  = (count_q == TERM_COUNT);
  assign e_shl     = {e_q[WIDTH-2:0], 1'b0};
  assign count_inc = count_q + CNT_W'(1);

  // NOTE: all state lives in this one clocked block and uses non-blocking
  // assignments, so every branch reads the pre-edge values of the registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      e_q     <= '0;
      acc_q   <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            x_q     <= in_x;
            e_q     <= in_e;
            acc_q   <= in_one;
            count_q <= '0;
            state_q <= ST_SCAN;
          end
        end

        // Leading zeros are skipped; the first one loads ACC with X directly.
        ST_SCAN: begin
          e_q     <= e_shl;
          count_q <= count_inc;
          if (e_msb) acc_q <= x_q;
          if (last_bit) begin
            state_q <= ST_DONE;
          end else if (e_msb) begin
            mul_a_q <= x_q;
            mul_b_q <= x_q;
            state_q <= ST_SQ_ISSUE;
          end
        end

        ST_SQ_ISSUE: state_q <= ST_SQ_WAIT;

        // E has not shifted yet, so its MSB is the bit being processed.
        ST_SQ_WAIT: begin
          if (mul_done) begin
            acc_q <= mul_result;
            if (e_msb) begin
              mul_a_q <= mul_result;
              mul_b_q <= x_q;
              state_q <= ST_MU_ISSUE;
            end else begin
              state_q <= ST_ADV;
            end
          end
        end

        ST_MU_ISSUE: state_q <= ST_MU_WAIT;

        ST_MU_WAIT: begin
          if (mul_done) begin
            acc_q   <= mul_result;
            state_q <= ST_ADV;
          end
        end

        ST_ADV: begin
          e_q     <= e_shl;
          count_q <= count_inc;
          if (last_bit) begin
            state_q <= ST_DONE;
          end else begin
            mul_a_q <= acc_q;
            mul_b_q <= acc_q;
            state_q <= ST_SQ_ISSUE;
          end
        end

        ST_DONE: state_q <= ST_IDLE;

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Moore outputs decoded straight from the state register.
  assign done      = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign mul_start = (state_q == ST_SQ_ISSUE) || (state_q == ST_MU_ISSUE);
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign result    = acc_q;

endmodule

// File: tb/tb_mont_exp.sv
// Scoreboard bench for mont_exp: a mod-97 multiplier model with R=1 sits on the mul_* ports,
// directed runs push expected results and a negedge monitor checks them on done.
module tb_mont_exp;
  import mont_exp_pkg::*;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] in_x = '0;
  logic [WIDTH-1:0] in_e = '0;
  logic [WIDTH-1:0] in_one = '0;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;
  logic             mul_start;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic             mul_done = 1'b0;
  logic [WIDTH-1:0] mul_result = '0;

  mont_exp dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .in_x      (in_x),
    .in_e      (in_e),
    .in_one    (in_one),
    .result    (result),
    .done      (done),
    .busy      (busy),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_done  (mul_done),
    .mul_result(mul_result)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- multiplier model: a*b mod 97, configurable latency ----------------
  int               lat = 3;
  bit               stray_en = 1'b0;
  bit               m_busy = 1'b0;
  bit               m_stale = 1'b0;
  int               m_cnt = 0;
  int               stab_bad = 0;
  logic [WIDTH-1:0] m_a, m_b, m_res;

  always @(negedge clk) begin
    mul_done = 1'b0;
    if (!resetn) m_stale = 1'b1;
    if (m_busy) begin
      if (!m_stale && (mul_a !== m_a || mul_b !== m_b)) stab_bad++;
      if (m_cnt <= 1) begin
        mul_done   = 1'b1;
        mul_result = m_res;
        m_busy     = 1'b0;
      end else begin
        m_cnt--;
      end
    end else if (stray_en && !mul_start && $urandom_range(0, 3) == 0) begin
      mul_done   = 1'b1;
      mul_result = '0;
    end
    if (mul_start) begin
      m_busy  = 1'b1;
      m_stale = 1'b0;
      m_cnt   = lat;
      m_a     = mul_a;
      m_b     = mul_b;
      m_res   = (mul_a * mul_b) % 97;
    end
  end

  // ---------------- scoreboard and monitor ----------------
  typedef struct {
    logic [WIDTH-1:0] res;
    int               muls;
    int               cyc;   // -1: latency not checked
  } exp_t;

  exp_t sb[$];
  bit   active = 1'b0;
  bit   done_prev = 1'b0;
  int   cyc = 0;
  int   muls = 0;
  int   stab_base = 0;
  int   runs_done = 0;

  always @(negedge clk) begin
    if (!resetn) begin
      active    = 1'b0;
      done_prev = 1'b0;
    end else begin
      if (done_prev) check("done_width", {380'd0, done}, '0);
      done_prev = done;
      if (active) begin
        cyc++;
        if (mul_start) muls++;
        if (done) begin
          active = 1'b0;
          runs_done++;
          if (sb.size() == 0) begin
            check("sb_underflow", WIDTH'(1), '0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("result", result, e.res);
            check("mul_count", WIDTH'(muls), WIDTH'(e.muls));
            check("operand_stable", WIDTH'(stab_bad - stab_base), '0);
            if (e.cyc >= 0) check("latency", WIDTH'(cyc), WIDTH'(e.cyc));
          end
        end
      end
      if (start && !busy) begin
        active    = 1'b1;
        cyc       = 0;
        muls      = 0;
        stab_base = stab_bad;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done) return;
      @(posedge clk); #2;
    end
    check("timeout_done", WIDTH'(1), '0);
  endtask

  task automatic run(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] e,
                     input logic [WIDTH-1:0] r, input int nmul, input int ncyc);
    exp_t item;
    item.res = r; item.muls = nmul; item.cyc = ncyc;
    sb.push_back(item);
    @(posedge clk); #2;
    start = 1'b1; in_x = x; in_e = e; in_one = WIDTH'(1);
    @(posedge clk); #2;
    start = 1'b0;
    wait_done(3000);
    @(posedge clk); #2;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_result"},    result, '0);
    check({tag, "_done"},      {380'd0, done}, '0);
    check({tag, "_busy"},      {380'd0, busy}, '0);
    check({tag, "_mul_start"}, {380'd0, mul_start}, '0);
    check({tag, "_mul_a"},     mul_a, '0);
    check({tag, "_mul_b"},     mul_b, '0);
  endtask

  initial begin
    int pulses;
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    resetn = 1'b1;

    // x=5, e=13: 5^13 mod 97 = 29, 3 squares + 2 multiplies
    run(WIDTH'(5), WIDTH'(13), WIDTH'(29), 5, -1);
    // e=0 and e=1: no multiplies, done 382 cycles after the start cycle
    run(WIDTH'(5), WIDTH'(0), WIDTH'(1), 0, 382);
    run(WIDTH'(5), WIDTH'(1), WIDTH'(5), 0, 382);
    run(WIDTH'(5), WIDTH'(2), WIDTH'(25), 1, -1);
    // 7^96 mod 97 = 1 (Fermat); e=0b1100000 -> 6 squares + 1 multiply
    lat = 1;
    run(WIDTH'(7), WIDTH'(96), WIDTH'(1), 7, -1);
    lat = 40;
    run(WIDTH'(7), WIDTH'(96), WIDTH'(1), 7, -1);
    lat = 3;

    // Reset while waiting on the first multiply (second mul_start of x=5,e=13)
    @(posedge clk); #2;
    start = 1'b1; in_x = WIDTH'(5); in_e = WIDTH'(13); in_one = WIDTH'(1);
    @(posedge clk); #2;
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 2000 && pulses < 2; i++) begin
      if (mul_start) pulses++;
      if (pulses < 2) begin @(posedge clk); #2; end
    end
    check("reach_mu_issue", WIDTH'(pulses), WIDTH'(2));
    @(posedge clk); #2;      // now in MU_WAIT with a multiply outstanding
    resetn = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clk); #2;
    resetn = 1'b1;
    repeat (8) @(posedge clk);
    #2;
    check("late_done_busy",   {380'd0, busy}, '0);
    check("late_done_result", result, '0);
    run(WIDTH'(5), WIDTH'(13), WIDTH'(29), 5, -1);

    // start held across two runs with stray mul_done pulses outside the WAIT states
    stray_en = 1'b1;
    begin
      exp_t item;
      int   base;
      item.res = WIDTH'(29); item.muls = 5; item.cyc = -1;
      sb.push_back(item);
      sb.push_back(item);
      base = runs_done;
      @(posedge clk); #2;
      start = 1'b1; in_x = WIDTH'(5); in_e = WIDTH'(13); in_one = WIDTH'(1);
      for (int i = 0; i < 4000 && runs_done < base + 2; i++) begin
        @(posedge clk); #2;
        if (done && runs_done == base + 1) start = 1'b0;
      end
      start = 1'b0;
      check("held_start_runs", WIDTH'(runs_done - base), WIDTH'(2));
    end
    stray_en = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("held_start_idle", {380'd0, busy}, '0);
    check("sb_empty", WIDTH'(sb.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
